// File: rtl/demux3_stream.sv
// ============================================================================
// Module   : demux3_stream
// Brief    : 1-to-3 valid/ready stream demultiplexer; each output has a single
//            registered buffer and an 8-bit delivery counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux3_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       sel,
    output logic             in_ready,

    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    input  logic             out0_ready,

    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    input  logic             out1_ready,

    output logic             out2_valid,
    output logic [WIDTH-1:0] out2_data,
    input  logic             out2_ready,

    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2,

    output logic             busy
);

    localparam int c_NPORTS = 3;

    logic [c_NPORTS-1:0] r_valid;
    logic [WIDTH-1:0]    r_data [c_NPORTS];
    logic [7:0]          r_cnt  [c_NPORTS];

    logic [c_NPORTS-1:0] w_out_ready;
    logic [c_NPORTS-1:0] w_deliver;
    logic [c_NPORTS-1:0] w_load;
    logic [1:0]          w_idx;
    logic                w_in_ready;

    assign w_out_ready = {out2_ready, out1_ready, out0_ready};

    // Both 2'b10 and 2'b11 route to port 2.
    always_comb begin
        w_idx = 2'd2;
        if (sel == 2'b00) begin
            w_idx = 2'd0;
        end else if (sel == 2'b01) begin
            w_idx = 2'd1;
        end
    end

    assign w_deliver = r_valid & w_out_ready;

    // Only the selected buffer's state decides acceptance; a draining full
    // buffer can be refilled in the same cycle.
    assign w_in_ready = ~r_valid[w_idx] | w_out_ready[w_idx];

    generate
        for (genvar n = 0; n < c_NPORTS; n++) begin : g_port
            assign w_load[n] = in_valid & w_in_ready & (w_idx == 2'(n));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid[n] <= 1'b0;
                    r_data[n]  <= '0;
                    r_cnt[n]   <= 8'd0;
                end else begin
                    if (w_load[n]) begin
                        r_valid[n] <= 1'b1;
                        r_data[n]  <= in_data;
                    end else if (w_deliver[n]) begin
                        r_valid[n] <= 1'b0;
                    end
                    if (w_deliver[n]) begin
                        r_cnt[n] <= r_cnt[n] + 8'd1;
                    end
                end
            end
        end
    endgenerate

    assign in_ready   = w_in_ready;

    assign out0_valid = r_valid[0];
    assign out1_valid = r_valid[1];
    assign out2_valid = r_valid[2];

    assign out0_data  = r_data[0];
    assign out1_data  = r_data[1];
    assign out2_data  = r_data[2];

    assign cnt0       = r_cnt[0];
    assign cnt1       = r_cnt[1];
    assign cnt2       = r_cnt[2];

    assign busy       = |r_valid;

endmodule

`default_nettype wire

// File: tb/tb_demux3_stream.sv
// ============================================================================
// Module   : tb_demux3_stream
// Brief    : Scoreboard bench for demux3_stream with directed and random traffic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_demux3_stream;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       sel;
    logic             in_ready;
    logic             out0_valid, out1_valid, out2_valid;
    logic [WIDTH-1:0] out0_data, out1_data, out2_data;
    logic             out0_ready, out1_ready, out2_ready;
    logic [7:0]       cnt0, cnt1, cnt2;
    logic             busy;

    demux3_stream #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .sel        (sel),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
        .out2_valid (out2_valid),
        .out2_data  (out2_data),
        .out2_ready (out2_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: each port is a queue of words accepted but not yet
    // delivered (capacity one), plus a wrapping delivery count.
    logic [WIDTH-1:0] exp_q [3][$];
    logic [7:0]       mcnt [3];
    int               errors = 0;
    int               checks = 0;
    bit               mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int port_of(input logic [1:0] s);
        return (s == 2'b00) ? 0 : (s == 2'b01) ? 1 : 2;
    endfunction

    // Monitor: compares visible buffer state with the model and retires
    // delivered words from the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            logic             v   [3];
            logic [WIDTH-1:0] d   [3];
            logic             r   [3];
            logic [7:0]       c   [3];
            bit               any;
            v = '{out0_valid, out1_valid, out2_valid};
            d = '{out0_data, out1_data, out2_data};
            r = '{out0_ready, out1_ready, out2_ready};
            c = '{cnt0, cnt1, cnt2};
            any = 1'b0;
            for (int n = 0; n < 3; n++) begin
                bit ev;
                ev = (exp_q[n].size() != 0);
                any |= ev;
                chk($sformatf("valid%0d", n), 32'(v[n]), 32'(ev));
                if (ev) chk($sformatf("data%0d", n), 32'(d[n]), 32'(exp_q[n][0]));
                chk($sformatf("cnt%0d", n), 32'(c[n]), 32'(mcnt[n]));
                if (ev && r[n]) begin
                    void'(exp_q[n].pop_front());
                    mcnt[n] = mcnt[n] + 8'd1;
                end
            end
            chk("busy", 32'(busy), 32'(any));
        end
    end

    // One clock of stimulus; in_ready is predicted from model occupancy
    // after this cycle's deliveries have been retired by the monitor.
    task automatic step(input bit v, input logic [1:0] s, input logic [7:0] dat,
                        input bit [2:0] rdy, input bit rst);
        int  p;
        bit  pred;
        reset      = rst;
        in_valid   = v;
        sel        = s;
        in_data    = dat;
        out0_ready = rdy[0];
        out1_ready = rdy[1];
        out2_ready = rdy[2];
        @(negedge clk);
        #1;
        p    = port_of(s);
        pred = (exp_q[p].size() == 0);
        chk("in_ready", 32'(in_ready), 32'(pred));
        if (rst) begin
            for (int n = 0; n < 3; n++) begin
                exp_q[n].delete();
                mcnt[n] = 8'd0;
            end
        end else if (v && pred) begin
            exp_q[p].push_back(dat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int n = 0; n < 3; n++) mcnt[n] = 8'd0;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; sel = 2'b00;
        out0_ready = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_data0", 32'(out0_data), 32'h0);
        chk("rst_data2", 32'(out2_data), 32'h0);
        mon_en = 1'b1;

        // Single word to port 0, then drain.
        step(1, 2'b00, 8'hA5, 3'b001, 0);
        step(0, 2'b00, 8'h00, 3'b001, 0);
        step(0, 2'b00, 8'h00, 3'b001, 0);
        chk("cnt0_one", 32'(cnt0), 32'd1);

        // Port 2 stalled via sel=11, second word via sel=10 waits for ready.
        step(1, 2'b11, 8'h3C, 3'b000, 0);
        step(1, 2'b10, 8'h77, 3'b000, 0);
        step(1, 2'b10, 8'h77, 3'b000, 0);
        step(1, 2'b10, 8'h77, 3'b100, 0);
        chk("out2_replaced", 32'(out2_data), 32'h77);
        chk("cnt2_one", 32'(cnt2), 32'd1);
        step(0, 2'b00, 8'h00, 3'b100, 0);

        // Back-to-back on port 1.
        for (int i = 0; i < 4; i++) step(1, 2'b01, 8'(8'h10 + i), 3'b010, 0);
        step(0, 2'b00, 8'h00, 3'b010, 0);
        chk("cnt1_four", 32'(cnt1), 32'd4);

        // Port 0 stalled while port 1 takes a word.
        step(1, 2'b00, 8'hE1, 3'b000, 0);
        step(1, 2'b01, 8'hE2, 3'b000, 0);
        chk("out0_held", 32'(out0_data), 32'hE1);

        // Reset with port 1 full.
        step(0, 2'b01, 8'h00, 3'b000, 1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_cnt1", 32'(cnt1), 32'd0);
        step(1, 2'b01, 8'h5A, 3'b000, 0);

        // Randomized traffic; long enough to wrap every counter.
        for (int i = 0; i < 3000; i++) begin
            bit [2:0] rdy;
            for (int n = 0; n < 3; n++) rdy[n] = ($urandom_range(0, 9) < 7);
            step(($urandom_range(0, 9) < 8), 2'($urandom), 8'($urandom), rdy, 0);
        end

        // 257 deliveries on port 2 from a cleared counter.
        step(0, 2'b00, 8'h00, 3'b000, 1);
        for (int i = 0; i < 257; i++) step(1, 2'b10, 8'($urandom), 3'b100, 0);
        step(0, 2'b00, 8'h00, 3'b100, 0);
        chk("cnt2_wrap", 32'(cnt2), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
